// File: rtl/uart_pkg.sv
// Shared constants and FSM state type for the uart_ports console peripheral.
package uart_pkg;
  localparam int TX_EMPTY = 0;
  localparam int TX_FULL  = 1;
  localparam int RX_READY = 2;
  localparam int RX_FULL  = 3;
  localparam int OVERRUN  = 4;
  localparam int LOOPBACK = 5;

  // Word offsets within the port pair (enum already owns the name DATA)
  localparam logic ADDR_DATA   = 1'b0;
  localparam logic ADDR_STATUS = 1'b1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with show-ahead head output; a pop frees room for a same-cycle push.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/uart_ports.sv
// Bus-mapped UART: DATA/STATUS words, TX and RX FIFOs, 8N1 serial engines.
// Optional UART_LOOPBACK_EN adds a STATUS-writable bit that routes uart_tx into the receiver.
module uart_ports
  import uart_pkg::*;
#(
  parameter int clkf       = 25000000,
  parameter int baud       = 115200,
  parameter int fifo_depth = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        data_m_addr,
  input  logic [15:0] data_m_data_in,
  output logic [15:0] data_m_data_out,
  input  logic        data_m_wr_en,
  input  logic [1:0]  data_m_bytesel,
  output logic        data_m_ack,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        rx_ready
);
  localparam int DIV  = (clkf + baud / 2) / baud;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV + 1);

  logic cs_q, ack_q, ack_d, ovr_q, ovr_d;
  logic wr_acc, rd_acc, st_rd, tx_push, rx_pop, ovr_set;
  logic [15:0] status;

  logic        tx_full, tx_empty, tx_pop;
  logic [7:0]  tx_head;
  uart_state_t tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        tx_q, tx_d, tx_bit_end;

  logic        rx_full, rx_empty, rx_push;
  logic [7:0]  rx_head;
  uart_state_t rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_in, rx_s1_q, rx_s2_q, rx_prev_q;
  logic        loop_bit;
  logic        unused_bits;

  assign unused_bits = ^{data_m_bytesel[1], data_m_data_in[15:8]};

`ifdef UART_LOOPBACK_EN
  logic loop_q, loop_d;
  always_comb begin
    loop_d = loop_q;
    if (wr_acc && data_m_addr == ADDR_STATUS && data_m_bytesel[0]) loop_d = data_m_data_in[0];
  end
  always_ff @(posedge clk) begin
    if (reset) loop_q <= 1'b0;
    else       loop_q <= loop_d;
  end
  assign loop_bit = loop_q;
  assign rx_in    = loop_q ? tx_q : uart_rx;
`else
  assign loop_bit = 1'b0;
  assign rx_in    = uart_rx;
`endif

  // Bus: every side effect is qualified by the single ack cycle
  always_comb begin
    ack_d   = cs && !cs_q;
    wr_acc  = ack_q && data_m_wr_en;
    rd_acc  = ack_q && !data_m_wr_en;
    st_rd   = rd_acc && data_m_addr == ADDR_STATUS;
    tx_push = wr_acc && data_m_addr == ADDR_DATA && data_m_bytesel[0];
    rx_pop  = rd_acc && data_m_addr == ADDR_DATA;
    ovr_set = rx_push && rx_full && !rx_pop;
    ovr_d   = (ovr_q && !st_rd) || ovr_set;

    status           = '0;
    status[TX_EMPTY] = tx_empty && tx_state_q == IDLE;
    status[TX_FULL]  = tx_full;
    status[RX_READY] = !rx_empty;
    status[RX_FULL]  = rx_full;
    status[OVERRUN]  = ovr_q;
    status[LOOPBACK] = loop_bit;

    data_m_data_out = '0;
    if (rd_acc) begin
      if (data_m_addr == ADDR_STATUS) data_m_data_out = status;
      else if (!rx_empty)             data_m_data_out = {8'h00, rx_head};
    end
  end

  assign data_m_ack = ack_q;
  assign uart_tx    = tx_q;
  assign rx_ready   = !rx_empty;

  uart_fifo #(.WIDTH(8), .DEPTH(fifo_depth)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(tx_push), .din(data_m_data_in[7:0]), .pop(tx_pop),
    .full(tx_full), .empty(tx_empty), .head(tx_head)
  );

  uart_fifo #(.WIDTH(8), .DEPTH(fifo_depth)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_push), .din(rx_shift_q), .pop(rx_pop),
    .full(rx_full), .empty(rx_empty), .head(rx_head)
  );

  // TX: STOP chains straight into START when more data is queued
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + CW'(1);
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    tx_pop     = 1'b0;
    tx_bit_end = (tx_cnt_q == CW'(DIV - 1));
    case (tx_state_q)
      IDLE: begin
        tx_cnt_d = '0;
        tx_d     = 1'b1;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_head;
          tx_state_d = START;
          tx_d       = 1'b0;
        end
      end
      START: if (tx_bit_end) begin
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_state_d = DATA;
        tx_d       = tx_shift_q[0];
      end
      DATA: if (tx_bit_end) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 3'd7) begin
          tx_state_d = STOP;
          tx_d       = 1'b1;
        end else begin
          tx_bit_d   = tx_bit_q + 3'd1;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_d       = tx_shift_q[1];
        end
      end
      STOP: if (tx_bit_end) begin
        tx_cnt_d = '0;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_head;
          tx_state_d = START;
          tx_d       = 1'b0;
        end else begin
          tx_state_d = IDLE;
        end
      end
      default: tx_state_d = IDLE;
    endcase
  end

  // RX: half-bit check rejects glitches, then one sample per bit centre
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CW'(1);
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    case (rx_state_q)
      IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_s2_q) rx_state_d = START;
      end
      START: if (rx_cnt_q == CW'(HALF - 1)) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s2_q ? IDLE : DATA;
      end
      DATA: if (rx_cnt_q == CW'(DIV - 1)) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
        rx_bit_d   = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = STOP;
      end
      STOP: if (rx_cnt_q == CW'(DIV - 1)) begin
        rx_cnt_d   = '0;
        rx_push    = rx_s2_q;
        rx_state_d = IDLE;
      end
      default: rx_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cs_q       <= 1'b0;
      ack_q      <= 1'b0;
      ovr_q      <= 1'b0;
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
      rx_state_q <= IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
    end else begin
      cs_q       <= cs;
      ack_q      <= ack_d;
      ovr_q      <= ovr_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_s1_q    <= rx_in;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
    end
  end
endmodule

// File: tb/tb_uart_ports.sv
// Directed bench for uart_ports at default parameters (217 clocks per bit).
`timescale 1ns/1ps
module tb_uart_ports;
  import uart_pkg::*;
  localparam int DIV = 217;

  logic        clk = 1'b0, reset = 1'b1, cs = 1'b0, addr = 1'b0, wr = 1'b0, uart_rx = 1'b1;
  logic [15:0] din = '0, dout;
  logic [1:0]  bsel = '0;
  logic        ack, uart_tx, rx_ready;
  int          n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  uart_ports dut (
    .clk(clk), .reset(reset), .cs(cs), .data_m_addr(addr), .data_m_data_in(din),
    .data_m_data_out(dout), .data_m_wr_en(wr), .data_m_bytesel(bsel), .data_m_ack(ack),
    .uart_rx(uart_rx), .uart_tx(uart_tx), .rx_ready(rx_ready)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic a, input logic w, input logic [15:0] d, output logic [15:0] rd);
    @(posedge clk); #1;
    cs = 1'b1; addr = a; wr = w; din = d; bsel = 2'b11;
    check("ack_before", 16'(ack), 16'd0);
    tick(1);
    check("ack_pulse", 16'(ack), 16'd1);
    rd = dout;
    tick(1);
    cs = 1'b0;
    check("ack_after", 16'(ack), 16'd0);
    check("dout_idle", dout, 16'h0000);
  endtask

  // Waits (bounded) for a start bit, then samples each bit at its centre
  task automatic tx_get(output logic [7:0] b, output logic ok);
    int t = 0;
    b = '0; ok = 1'b0;
    while (uart_tx !== 1'b0 && t < 3 * DIV) begin tick(1); t++; end
    if (t >= 3 * DIV) return;
    tick(DIV / 2);
    ok = (uart_tx === 1'b0);
    for (int i = 0; i < 8; i++) begin tick(DIV); b[i] = uart_tx; end
    tick(DIV);
    ok = ok && (uart_tx === 1'b1);
  endtask

  task automatic rx_send(input logic [7:0] b);
    uart_rx = 1'b0; tick(DIV);
    for (int i = 0; i < 8; i++) begin uart_rx = b[i]; tick(DIV); end
    uart_rx = 1'b1; tick(DIV);
  endtask

  logic [15:0] rd, rd2, got;
  logic [7:0]  b, bits;
  logic        ok;
  int          low_len, acks, t;

  initial begin
    tick(3);
    reset = 1'b0;
    check("rst_tx", 16'(uart_tx), 16'd1);
    check("rst_ack", 16'(ack), 16'd0);
    check("rst_dout", dout, 16'h0000);
    check("rst_rx_ready", 16'(rx_ready), 16'd0);
    bus(ADDR_STATUS, 1'b0, 16'h0, rd);
    check("rst_status", rd, 16'h0001);

    // Single byte 0x55: start bit length, then LSB-first bits and stop
    bus(ADDR_DATA, 1'b1, 16'h0055, rd);
    t = 0;
    while (uart_tx !== 1'b0 && t < 20) begin tick(1); t++; end
    low_len = 0;
    while (uart_tx === 1'b0 && low_len < 1000) begin tick(1); low_len++; end
    check("tx_start_len", 16'(low_len), 16'd217);
    tick(DIV / 2);
    bits = '0;
    for (int i = 0; i < 8; i++) begin bits[i] = uart_tx; if (i < 7) tick(DIV); end
    check("tx_bits_55", 16'(bits), 16'h0055);
    tick(DIV);
    check("tx_stop", 16'(uart_tx), 16'd1);
    tick(DIV);
    bus(ADDR_STATUS, 1'b0, 16'h0, rd);
    check("tx_status_done", rd, 16'h0001);

    // Nine queued writes: first is popped at once, the other eight fit
    fork
      begin for (int i = 1; i <= 9; i++) bus(ADDR_DATA, 1'b1, 16'(i), rd); end
      begin
        logic [7:0] rb; logic rok;
        for (int i = 1; i <= 9; i++) begin
          tx_get(rb, rok);
          check("tx9_frame_ok", 16'(rok), 16'd1);
          check("tx9_byte", 16'(rb), 16'(i));
        end
      end
    join
    tick(DIV);

    // Ten writes: the tenth lands on a full FIFO and is dropped
    fork
      begin
        for (int i = 1; i <= 10; i++) bus(ADDR_DATA, 1'b1, 16'(i), rd);
        bus(ADDR_STATUS, 1'b0, 16'h0, rd2);
        check("tx_full_status", rd2, 16'h0002);
      end
      begin
        logic [7:0] rb; logic rok;
        for (int i = 1; i <= 9; i++) begin
          tx_get(rb, rok);
          check("tx10_byte", 16'(rb), 16'(i));
        end
        tx_get(rb, rok);
        check("tx10_no_tenth", 16'(rok), 16'd0);
      end
    join

    // RX single frame
    check("rx_idle_ready", 16'(rx_ready), 16'd0);
    rx_send(8'hA3);
    check("rx_ready_set", 16'(rx_ready), 16'd1);
    bus(ADDR_DATA, 1'b0, 16'h0, rd);
    check("rx_data_a3", rd, 16'h00A3);
    check("rx_ready_clr", 16'(rx_ready), 16'd0);
    bus(ADDR_DATA, 1'b0, 16'h0, rd);
    check("rx_empty_read", rd, 16'h0000);

    // Nine frames unread; TX is idle so tx_empty (bit0) also reads 1
    for (int i = 0; i < 9; i++) rx_send(8'h10 + 8'(i));
    bus(ADDR_STATUS, 1'b0, 16'h0, rd);
    check("ovr_status", rd & 16'hFFFE, 16'h001C);
    check("ovr_tx_empty", 16'(rd[0]), 16'd1);
    bus(ADDR_STATUS, 1'b0, 16'h0, rd);
    check("ovr_cleared", rd & 16'hFFFE, 16'h000C);
    for (int i = 0; i < 8; i++) begin
      bus(ADDR_DATA, 1'b0, 16'h0, rd);
      check("ovr_drain", rd, 16'h0010 + 16'(i));
    end
    check("ovr_drained", 16'(rx_ready), 16'd0);

    // 50-clock low glitch must not start a byte
    uart_rx = 1'b0; tick(50); uart_rx = 1'b1;
    tick(12 * DIV);
    check("glitch_no_byte", 16'(rx_ready), 16'd0);

    // cs held five cycles on a DATA read: one ack, one pop
    rx_send(8'h11);
    rx_send(8'h22);
    @(posedge clk); #1;
    cs = 1'b1; addr = ADDR_DATA; wr = 1'b0; acks = 0; got = '0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (ack === 1'b1) begin acks++; got = dout; end
    end
    cs = 1'b0;
    tick(2);
    check("held_acks", 16'(acks), 16'd1);
    check("held_data", got, 16'h0011);
    bus(ADDR_DATA, 1'b0, 16'h0, rd);
    check("held_next", rd, 16'h0022);
    check("held_empty", 16'(rx_ready), 16'd0);

`ifdef UART_LOOPBACK_EN
    bus(ADDR_STATUS, 1'b1, 16'h0001, rd);
    bus(ADDR_STATUS, 1'b0, 16'h0, rd);
    check("lb_status", rd, 16'h0021);
    uart_rx = 1'b0;
    bus(ADDR_DATA, 1'b1, 16'h005A, rd);
    tick(11 * DIV);
    bus(ADDR_DATA, 1'b0, 16'h0, rd);
    check("lb_data", rd, 16'h005A);
    check("lb_rx_empty", 16'(rx_ready), 16'd0);
    uart_rx = 1'b1;
    tick(2);
    bus(ADDR_STATUS, 1'b1, 16'h0000, rd);
`else
    bus(ADDR_STATUS, 1'b1, 16'h0001, rd);
    bus(ADDR_STATUS, 1'b0, 16'h0, rd);
    check("nolb_status", rd, 16'h0001);
`endif

    // Reset mid-frame on both directions
    bus(ADDR_DATA, 1'b1, 16'h0000, rd);
    uart_rx = 1'b0;
    tick(300);
    check("mid_tx_low", 16'(uart_tx), 16'd0);
    reset = 1'b1; uart_rx = 1'b1;
    tick(1);
    check("mid_rst_tx", 16'(uart_tx), 16'd1);
    reset = 1'b0;
    tick(12 * DIV);
    check("mid_rst_rx_drop", 16'(rx_ready), 16'd0);
    bus(ADDR_STATUS, 1'b0, 16'h0, rd);
    check("mid_rst_status", rd, 16'h0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
